// File: rtl/frame_batch_sched_if.sv
// Signal bundle between the batch scheduler, its host and the per-frame pipeline controller.
// Handshakes: batch_start is taken only while busy=0 and no error is latched; start_sys is a
// one-cycle launch; intr_sys is a level answered by intr_clr_sys, held until intr_sys drops.
interface frame_batch_sched_if #(
    parameter int ADDR_W = 19,
    parameter int CNT_W  = 10
);
    logic              batch_start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  frame_count;
    logic [ADDR_W-1:0] frame_stride;
    logic              abort;
    logic              done_clr;
    logic              start_sys;
    logic [ADDR_W-1:0] start_music_addr;
    logic              intr_sys;
    logic              intr_clr_sys;
    logic              busy;
    logic [CNT_W-1:0]  frames_done;
    logic              batch_done;
    logic              aborted;
    logic              err_timeout;
    logic              err_wrap;

    // master is the scheduler itself; slave is the host plus frame controller side.
    modport master (
        input  batch_start, base_addr, frame_count, frame_stride, abort, done_clr, intr_sys,
        output start_sys, start_music_addr, intr_clr_sys, busy, frames_done,
               batch_done, aborted, err_timeout, err_wrap
    );

    modport slave (
        output batch_start, base_addr, frame_count, frame_stride, abort, done_clr, intr_sys,
        input  start_sys, start_music_addr, intr_clr_sys, busy, frames_done,
               batch_done, aborted, err_timeout, err_wrap
    );
endinterface

// File: rtl/frame_batch_sched.sv
// Runs a batch of frames through the per-frame controller, stepping the sample address
// by a fixed stride and reporting completion, abort, timeout and address-wrap outcomes.
module frame_batch_sched #(
    parameter int ADDR_W  = 19,
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic                clk_in,
    input  logic                rst_n,
    frame_batch_sched_if.master bus,
    output logic [2:0]          dbg_state
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_FRAME, S_CLEAR, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, cfg_stride;
    logic [CNT_W-1:0]  cfg_count, frames_done;
    logic [TW-1:0]     timer;
    logic              busy, batch_done, aborted, err_timeout, err_wrap;

    logic              accept, adv_addr, frame_inc;
    logic              set_done, set_abort, set_tmo, set_wrap;
    logic [ADDR_W:0]   addr_sum;
    logic [CNT_W-1:0]  fd_inc;

    // The extra top bit of the sum is the carry that flags an address wrap.
    assign addr_sum = {1'b0, addr} + {1'b0, cfg_stride};
    assign fd_inc   = frames_done + CNT_W'(1);

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        adv_addr  = 1'b0;
        frame_inc = 1'b0;
        set_done  = 1'b0;
        set_abort = 1'b0;
        set_tmo   = 1'b0;
        set_wrap  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.batch_start && !busy && !err_timeout && !err_wrap) begin
                    accept   = 1'b1;
                    state_nx = (bus.frame_count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE:      state_nx = S_WAIT_FRAME;
            S_WAIT_FRAME: begin
                if (bus.intr_sys) begin
                    state_nx = S_CLEAR;
                end else if (timer == TMO_LAST) begin
                    state_nx = S_ERROR;
                    set_tmo  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (!bus.intr_sys) state_nx = S_NEXT;
            end
            S_NEXT: begin
                // Completion outranks abort, which outranks the wrap check.
                frame_inc = 1'b1;
                if (fd_inc == cfg_count) begin
                    state_nx = S_DONE;
                end else if (bus.abort) begin
                    state_nx  = S_DONE;
                    set_abort = 1'b1;
                end else if (addr_sum[ADDR_W]) begin
                    state_nx = S_ERROR;
                    set_wrap = 1'b1;
                end else begin
                    adv_addr = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_DONE: begin
                set_done = !aborted;
                state_nx = S_IDLE;
            end
            S_ERROR: begin
                if (bus.done_clr) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr        <= '0;
            cfg_stride  <= '0;
            cfg_count   <= '0;
            frames_done <= '0;
            timer       <= '0;
            busy        <= 1'b0;
            batch_done  <= 1'b0;
            aborted     <= 1'b0;
            err_timeout <= 1'b0;
            err_wrap    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr        <= bus.base_addr;
                cfg_stride  <= bus.frame_stride;
                cfg_count   <= bus.frame_count;
                frames_done <= '0;
            end
            if (adv_addr)  addr        <= addr_sum[ADDR_W-1:0];
            if (frame_inc) frames_done <= fd_inc;

            if (state == S_ISSUE) begin
                timer <= '0;
            end else if (state == S_WAIT_FRAME && state_nx == S_WAIT_FRAME) begin
                timer <= timer + TW'(1);
            end

            if (state_nx == S_DONE || state_nx == S_ERROR) busy <= 1'b0;
            else if (accept)                               busy <= 1'b1;

            // Sticky flags: a set in the same cycle as a clear is kept.
            if (set_done)                     batch_done  <= 1'b1;
            else if (bus.done_clr || accept)  batch_done  <= 1'b0;
            if (set_abort)                    aborted     <= 1'b1;
            else if (bus.done_clr || accept)  aborted     <= 1'b0;
            if (set_tmo)                      err_timeout <= 1'b1;
            else if (bus.done_clr)            err_timeout <= 1'b0;
            if (set_wrap)                     err_wrap    <= 1'b1;
            else if (bus.done_clr)            err_wrap    <= 1'b0;
        end
    end

    assign bus.start_sys        = (state == S_ISSUE);
    assign bus.intr_clr_sys     = (state == S_CLEAR);
    assign bus.start_music_addr = addr;
    assign bus.busy             = busy;
    assign bus.frames_done      = frames_done;
    assign bus.batch_done       = batch_done;
    assign bus.aborted          = aborted;
    assign bus.err_timeout      = err_timeout;
    assign bus.err_wrap         = err_wrap;
    assign dbg_state            = state;
endmodule

// File: tb/tb_frame_batch_sched.sv
// Bench for frame_batch_sched: directed batches plus random ones, checked against a
// frame-by-frame outcome model and a per-cycle monitor of the start/clear traffic.
module tb_frame_batch_sched;
  localparam int ADDR_W  = 19;
  localparam int CNT_W   = 10;
  localparam int TIMEOUT = 100;

  logic       clk_in;
  logic       rst_n;
  logic [2:0] dbg_state;

  frame_batch_sched_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  frame_batch_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required test end first");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks;
  int n_fail;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] obs_q[$];
  int exp_fd;
  bit exp_done, exp_abort, exp_tmo, exp_wrap;
  int last_n_start, last_n_end;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] obs_at(input int i);
    if (i < obs_q.size()) return 32'(obs_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // Outcome model: walk the frames with plain arithmetic and record what must happen.
  function automatic void build_expect(input logic [ADDR_W-1:0] base, input int count,
                                       input logic [ADDR_W-1:0] stride, input int abort_at,
                                       input bit hang);
    longint a;
    a = longint'(base);
    exp_fd = 0; exp_done = 0; exp_abort = 0; exp_tmo = 0; exp_wrap = 0;
    exp_q.delete();
    if (count == 0) begin
      exp_done = 1;
      return;
    end
    for (int f = 1; f <= count; f++) begin
      exp_q.push_back(ADDR_W'(a));
      if (hang) begin
        exp_tmo = 1;
        return;
      end
      exp_fd = f;
      if (f == count) begin
        exp_done = 1;
        return;
      end
      if (abort_at != 0 && f >= abort_at) begin
        exp_abort = 1;
        return;
      end
      if (a + longint'(stride) > (longint'(1) << ADDR_W) - 1) begin
        exp_wrap = 1;
        return;
      end
      a = a + longint'(stride);
    end
  endfunction

  // downstream frame controller: raises intr_sys resp_delay cycles after start_sys
  int resp_delay;
  bit resp_hang;
  bit resp_armed;
  int resp_cnt;

  always @(negedge clk_in) begin
    if (!rst_n) begin
      bus.intr_sys = 1'b0;
      resp_armed   = 1'b0;
    end else begin
      if (bus.start_sys && !resp_hang) begin
        resp_armed = 1'b1;
        resp_cnt   = resp_delay;
      end else if (resp_armed) begin
        resp_cnt--;
        if (resp_cnt <= 0) begin
          bus.intr_sys = 1'b1;
          resp_armed   = 1'b0;
        end
      end
      if (bus.intr_sys && bus.intr_clr_sys) bus.intr_sys = 1'b0;
    end
  end

  // compare process: every start must match the model, be one cycle, and hold its address
  bit prev_start, prev_clr, in_frame;
  logic [ADDR_W-1:0] frame_addr;

  always @(negedge clk_in) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      prev_clr   = 1'b0;
      in_frame   = 1'b0;
    end else begin
      if (bus.start_sys) begin
        check("start_one_cycle", 32'(prev_start), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_start: got start_sys at 0x%0h, required none", bus.start_music_addr);
        end else begin
          check("start_addr", 32'(bus.start_music_addr), 32'(exp_q.pop_front()));
        end
        obs_q.push_back(bus.start_music_addr);
        in_frame   = 1'b1;
        frame_addr = bus.start_music_addr;
      end else if (in_frame) begin
        check("addr_stable", 32'(bus.start_music_addr), 32'(frame_addr));
        if ((prev_clr && !bus.intr_clr_sys) || !bus.busy) in_frame = 1'b0;
      end
      if (bus.intr_clr_sys) check("clr_while_busy", 32'(bus.busy), 32'd1);
      prev_start = bus.start_sys;
      prev_clr   = bus.intr_clr_sys;
    end
  end

  // driver tasks
  task automatic pulse_done_clr();
    @(negedge clk_in);
    bus.done_clr = 1'b1;
    @(negedge clk_in);
    bus.done_clr = 1'b0;
  endtask

  task automatic run_batch(input logic [ADDR_W-1:0] base, input int count,
                           input logic [ADDR_W-1:0] stride, input int delay, input int abort_at,
                           input bit hang, input bit clr_first, input string tag);
    int n, starts, exp_starts;
    bit fin;
    if (clr_first) pulse_done_clr();
    build_expect(base, count, stride, abort_at, hang);
    exp_starts = exp_q.size();
    obs_q.delete();
    resp_delay = delay;
    resp_hang  = hang;
    @(negedge clk_in);
    bus.base_addr    = base;
    bus.frame_count  = CNT_W'(count);
    bus.frame_stride = stride;
    bus.batch_start  = 1'b1;
    n = 0; starts = 0; fin = 1'b0; last_n_start = 0;
    while (!fin && n < 3000) begin
      @(negedge clk_in);
      n++;
      bus.batch_start = 1'b0;
      if (n == 1) begin
        check({tag, "_busy_on_accept"}, 32'(bus.busy), 32'(count != 0));
        check({tag, "_flags_clr_on_accept"}, 32'({bus.batch_done, bus.aborted}), 32'd0);
      end
      if (bus.start_sys) begin
        starts++;
        if (last_n_start == 0) last_n_start = n;
      end
      if (abort_at != 0 && starts >= abort_at) bus.abort = 1'b1;
      fin = bus.batch_done | bus.aborted | bus.err_timeout | bus.err_wrap;
    end
    last_n_end = n;
    check({tag, "_finished"}, 32'(fin), 32'd1);
    @(negedge clk_in);
    check({tag, "_frames_done"}, 32'(bus.frames_done), 32'(exp_fd));
    check({tag, "_batch_done"},  32'(bus.batch_done),  32'(exp_done));
    check({tag, "_aborted"},     32'(bus.aborted),     32'(exp_abort));
    check({tag, "_err_timeout"}, 32'(bus.err_timeout), 32'(exp_tmo));
    check({tag, "_err_wrap"},    32'(bus.err_wrap),    32'(exp_wrap));
    check({tag, "_busy_off"},    32'(bus.busy),        32'd0);
    check({tag, "_start_count"}, 32'(starts),          32'(exp_starts));
    bus.abort = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl_outs"}, 32'({bus.start_sys, bus.intr_clr_sys, bus.busy, bus.batch_done,
                                    bus.aborted, bus.err_timeout, bus.err_wrap}), 32'd0);
    check({tag, "_addr"}, 32'(bus.start_music_addr), 32'd0);
    check({tag, "_frames_done"}, 32'(bus.frames_done), 32'd0);
  endtask

  // main sequence
  initial begin
    int starts;
    logic [ADDR_W-1:0] rb, rs;
    int rc, rd, ra;
    n_checks = 0;
    n_fail   = 0;
    bus.batch_start  = 1'b0;
    bus.base_addr    = '0;
    bus.frame_count  = '0;
    bus.frame_stride = '0;
    bus.abort        = 1'b0;
    bus.done_clr     = 1'b0;
    resp_delay = 1;
    resp_hang  = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;

    // count 0 finishes without any frame, batch_done after two edges
    run_batch(19'h00123, 0, 19'h00010, 5, 0, 0, 1, "zero");
    check("zero_latency", 32'(last_n_end), 32'd2);

    // basic batch, started while batch_done is still set from the previous one
    run_batch(19'h00100, 3, 19'h00400, 50, 0, 0, 0, "basic");
    check("basic_addr0", obs_at(0), 32'h00100);
    check("basic_addr1", obs_at(1), 32'h00500);
    check("basic_addr2", obs_at(2), 32'h00900);
    check("basic_fd_lit", 32'(bus.frames_done), 32'd3);

    // abort during frame 2 lets frame 2 finish
    run_batch(19'h00000, 5, 19'h00010, 10, 2, 0, 1, "abort");
    check("abort_fd_lit", 32'(bus.frames_done), 32'd2);
    check("abort_flag_lit", 32'({bus.aborted, bus.batch_done}), 32'b10);

    // restart straight after an aborted batch
    run_batch(19'h00200, 1, 19'h00010, 2, 0, 0, 0, "after_abort");

    // abort on the last frame loses to completion
    run_batch(19'h00300, 2, 19'h00010, 4, 2, 0, 1, "abort_last");

    // timeout: ERROR entered after the 100th wait cycle
    run_batch(19'h00040, 3, 19'h00010, 1, 0, 1, 1, "tmo");
    check("tmo_latency", 32'(last_n_end - last_n_start), 32'(TIMEOUT + 1));
    pulse_done_clr();
    check("tmo_cleared", 32'({bus.err_timeout, bus.err_wrap, bus.batch_done, bus.aborted, bus.busy}), 32'd0);

    // address wrap after frame 1
    run_batch(19'h7FC00, 4, 19'h00800, 4, 0, 0, 1, "wrap");
    check("wrap_fd_lit", 32'(bus.frames_done), 32'd1);
    check("wrap_flag_lit", 32'(bus.err_wrap), 32'd1);

    // reset in the middle of frame 2
    pulse_done_clr();
    build_expect(19'h01000, 5, 19'h00040, 0, 0);
    resp_delay = 20;
    resp_hang  = 1'b0;
    @(negedge clk_in);
    bus.base_addr    = 19'h01000;
    bus.frame_count  = CNT_W'(5);
    bus.frame_stride = 19'h00040;
    bus.batch_start  = 1'b1;
    starts = 0;
    for (int n = 0; n < 500 && starts < 2; n++) begin
      @(negedge clk_in);
      bus.batch_start = 1'b0;
      if (bus.start_sys) starts++;
    end
    check("rst_reached_frame2", 32'(starts), 32'd2);
    repeat (5) @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      check("post_rst_quiet", 32'({bus.start_sys, bus.intr_clr_sys, bus.busy}), 32'd0);
    end
    run_batch(19'h03000, 2, 19'h00020, 3, 0, 0, 1, "post_rst");
    check("post_rst_first_addr", obs_at(0), 32'h03000);

    // random batches
    for (int i = 0; i < 12; i++) begin
      rb = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      rs = ADDR_W'($urandom_range(0, 32'h10000));
      rc = int'($urandom_range(0, 6));
      rd = int'($urandom_range(1, 8));
      ra = 0;
      if (rc > 0 && $urandom_range(0, 2) == 0) ra = int'($urandom_range(1, rc));
      run_batch(rb, rc, rs, rd, ra, 0, 1, "rand");
    end

    repeat (3) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
